// File: rtl/vga_timing_pkg.sv
// Purpose: shared lock-FSM encoding and default 640x480@60 raster constants for the sync tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: lock_state_t, VGA_* timing defaults, GOOD_W, sync_idle() helper.
package vga_timing_pkg;

  // Default 640x480 raster, totals include blanking.
  localparam int VGA_TOTAL_COLS  = 800;
  localparam int VGA_TOTAL_ROWS  = 525;
  localparam int VGA_ACTIVE_COLS = 640;
  localparam int VGA_ACTIVE_ROWS = 480;
  localparam int VGA_COL_W       = 10;
  localparam int VGA_ROW_W       = 10;

  // Width of the consecutive-good-frame counter (LOCK_FRAMES tops out at 15).
  localparam int GOOD_W = 4;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  // Idle (deasserted) level of a sync whose active level is pol.
  function automatic logic sync_idle(input bit pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/sync_pipe.sv
// Purpose: fixed-depth delay line for one sync signal, reset to its idle level.
// Latency: DEPTH clocks from i_sync to o_sync.
// Backpressure: none; one sample accepted every clock.
// Ports: i_clk, i_rst_n (async active-low), i_sync in; o_sync = last stage,
//        o_pre = stage feeding o_sync (i_sync itself when DEPTH == 1).
module sync_pipe
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter bit POL   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_sync,
  output logic o_pre
);

  logic [DEPTH-1:0] r_stage;
  // w_chain[0] is the raw input, w_chain[k] is stage k-1; lets DEPTH == 1 share the same code.
  logic [DEPTH:0]   w_chain;

  assign w_chain = {r_stage, i_sync};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= {DEPTH{sync_idle(POL)}};
    end else begin
      r_stage <= w_chain[DEPTH-1:0];
    end
  end

  assign o_sync = w_chain[DEPTH];
  assign o_pre  = w_chain[DEPTH-1];

endmodule

// File: rtl/sync_track.sv
// Purpose: delays incoming h/v syncs, tracks raster position and qualifies frame timing (lock/err).
// Latency: syncs SYNC_DELAY clocks; counters aligned so (0,0) is the first cycle o_vsync is asserted.
// Backpressure: none; free-running on every pixel clock.
// Ports: i_clk, i_rst_n, i_hsync, i_vsync in; o_hsync, o_vsync, o_col_count, o_row_count,
//        o_active, o_locked, o_err (1-clock pulse), o_frame_cnt (8-bit wrapping) out.
module sync_track
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
  parameter int COL_W       = VGA_COL_W,
  parameter int ROW_W       = VGA_ROW_W,
  parameter int SYNC_DELAY  = 1,
  parameter bit HSYNC_POL   = 1'b1,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [COL_W-1:0] o_col_count,
  output logic [ROW_W-1:0] o_row_count,
  output logic             o_active,
  output logic             o_locked,
  output logic             o_err,
  output logic [7:0]       o_frame_cnt
);

  localparam logic [COL_W-1:0]  LP_COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0]  LP_ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [COL_W-1:0]  LP_COL_ACT  = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0]  LP_ROW_ACT  = ROW_W'(ACTIVE_ROWS);
  localparam logic [GOOD_W-1:0] LP_LOCK_N   = GOOD_W'(LOCK_FRAMES);

  // Reset: asserts asynchronously, releases two clocks after i_rst_n rises so every
  // flop leaves reset on the same edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Sync delay lines.
  logic w_vs_pre;
  // hsync is delayed only; its pre-output stage has no consumer.
  logic w_hs_pre_unused;

  sync_pipe #(
    .DEPTH (SYNC_DELAY),
    .POL   (HSYNC_POL)
  ) u_hs_pipe (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_sync  (i_hsync),
    .o_sync  (o_hsync),
    .o_pre   (w_hs_pre_unused)
  );

  sync_pipe #(
    .DEPTH (SYNC_DELAY),
    .POL   (VSYNC_POL)
  ) u_vs_pipe (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_sync  (i_vsync),
    .o_sync  (o_vsync),
    .o_pre   (w_vs_pre)
  );

  // Frame start = vsync about to assert at the output. Loading zero on this cycle puts
  // (0,0) on the counters in the first cycle o_vsync is asserted.
  logic w_fs;
  assign w_fs = (w_vs_pre == VSYNC_POL) && (o_vsync != VSYNC_POL);

  // Raster position counters, freewheeling between frame starts.
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_wrap;
  logic             w_wrap;

  assign w_col_wrap = (r_col == LP_COL_LAST);
  assign w_wrap     = w_col_wrap && (r_row == LP_ROW_LAST);

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_fs) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_col_wrap) begin
      r_col <= '0;
      r_row <= (r_row == LP_ROW_LAST) ? '0 : r_row + ROW_W'(1);
    end else begin
      r_col <= r_col + COL_W'(1);
    end
  end

  assign o_col_count = r_col;
  assign o_row_count = r_row;
  // Gated by reset so every output reads 0 while reset is held.
  assign o_active    = w_rst_n && (r_col < LP_COL_ACT) && (r_row < LP_ROW_ACT);

  // Frame counter.
  logic [7:0] r_frame_cnt;

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frame_cnt <= 8'd0;
    end else if (w_fs) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;

  // Lock qualification. Frame start and wrap point on the same cycle is one good frame;
  // either one alone is a mismatch.
  logic w_good;
  logic w_mismatch;

  assign w_good     = w_fs && w_wrap;
  assign w_mismatch = w_fs ^ w_wrap;

  lock_state_t       r_state;
  lock_state_t       w_state_nxt;
  logic [GOOD_W-1:0] r_good;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [GOOD_W-1:0] w_good_inc;
  logic              r_locked;
  logic              w_locked_nxt;
  logic              w_err;

  assign w_good_inc = r_good + GOOD_W'(1);

  // State register.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_UNLOCKED;
      r_good   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_fs) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_good) begin
          w_good_nxt = w_good_inc;
          if (w_good_inc == LP_LOCK_N) begin
            w_state_nxt = ST_LOCKED;
          end
        end else if (w_mismatch) begin
          w_good_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (w_mismatch) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
        w_good_nxt  = '0;
      end
    endcase
  end

  // Outputs. o_locked is registered from the next state so it tracks r_state exactly.
  always_comb begin
    w_err        = w_mismatch && (r_state != ST_UNLOCKED);
    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  assign o_err    = w_err;
  assign o_locked = r_locked;

endmodule

// File: tb/tb_sync_track.sv
`timescale 1ns/1ps
module tb_sync_track;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_hsync;
  logic       i_vsync;
  logic       o_hsync;
  logic       o_vsync;
  logic [3:0] o_col_count;
  logic [2:0] o_row_count;
  logic       o_active;
  logic       o_locked;
  logic       o_err;
  logic [7:0] o_frame_cnt;

  sync_track #(
    .TOTAL_COLS  (10),
    .TOTAL_ROWS  (6),
    .ACTIVE_COLS (8),
    .ACTIVE_ROWS (4),
    .COL_W       (4),
    .ROW_W       (3),
    .SYNC_DELAY  (3),
    .HSYNC_POL   (1'b1),
    .VSYNC_POL   (1'b1),
    .LOCK_FRAMES (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_hsync     (i_hsync),
    .i_vsync     (i_vsync),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_col_count (o_col_count),
    .o_row_count (o_row_count),
    .o_active    (o_active),
    .o_locked    (o_locked),
    .o_err       (o_err),
    .o_frame_cnt (o_frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Bench-side history and position model.
  logic [3:0] vs_hist = 4'd0;
  logic [3:0] hs_hist = 4'd0;
  int  mcol = 0, mrow = 0;
  bit  mvalid = 1'b0;
  int  fs_exp = 0;
  int  n_err = 0, n_active = 0, n_pos_bad = 0, n_dly_bad = 0, n_act_bad = 0;
  int  err_col = -1, err_row = -1;
  int  pos2_col = -1, pos2_row = -1;
  int  prev_fc = 0;
  bit  saw_wrap = 1'b0;

  task automatic clear_stats();
    n_err = 0; n_active = 0; n_pos_bad = 0; n_dly_bad = 0; n_act_bad = 0;
    err_col = -1; err_row = -1;
  endtask

  task automatic idle(input int n);
    i_vsync = 1'b0;
    i_hsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      vs_hist = {vs_hist[2:0], 1'b0};
      hs_hist = {hs_hist[2:0], 1'b0};
    end
  endtask

  // One frame of len clocks: vsync high for 2 clocks at the start (if vs_on), hsync every 10.
  task automatic frame(input int len, input bit vs_on);
    bit vs, hs;
    for (int i = 0; i < len; i++) begin
      vs = vs_on && (i < 2);
      hs = ((i % 10) == 0);
      i_vsync = vs;
      i_hsync = hs;
      @(posedge i_clk); #1;
      vs_hist = {vs_hist[2:0], vs};
      hs_hist = {hs_hist[2:0], hs};
      if (o_vsync !== vs_hist[2]) n_dly_bad++;
      if (o_hsync !== hs_hist[2]) n_dly_bad++;
      if (vs_hist[2] && !vs_hist[3]) begin
        mcol = 0; mrow = 0; mvalid = 1'b1; fs_exp++;
      end else if (mvalid) begin
        if (mcol == 9) begin
          mcol = 0;
          mrow = (mrow == 5) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end
      if (mvalid && (o_col_count !== 4'(mcol) || o_row_count !== 3'(mrow))) n_pos_bad++;
      if (mvalid && (o_active !== ((mcol < 8) && (mrow < 4)))) n_act_bad++;
      if (o_active === 1'b1) n_active++;
      if (o_err === 1'b1) begin
        n_err++; err_col = int'(o_col_count); err_row = int'(o_row_count);
      end
      if (i == 2) begin
        pos2_col = int'(o_col_count); pos2_row = int'(o_row_count);
      end
      if (prev_fc == 255 && int'(o_frame_cnt) == 0) saw_wrap = 1'b1;
      prev_fc = int'(o_frame_cnt);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; i_vsync = 1'b0; i_hsync = 1'b0;
    #2 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (o_col_count !== 4'd0) begin bad++; $display("FAIL rst_col: got %0d expected 0", o_col_count); end
    total++; if (o_row_count !== 3'd0) begin bad++; $display("FAIL rst_row: got %0d expected 0", o_row_count); end
    total++; if (o_frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d expected 0", o_frame_cnt); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b expected 0", o_err); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b expected 0", o_locked); end
    total++; if (o_vsync !== 1'b0 || o_hsync !== 1'b0) begin bad++; $display("FAIL rst_syncs: got v=%b h=%b expected 0 0", o_vsync, o_hsync); end
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL rst_active: got %b expected 0", o_active); end
    i_rst_n = 1'b1;
    idle(5);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL rst_release_locked: got %b expected 0", o_locked); end
  endtask

  task automatic test_lock_acquire();
    clear_stats();
    frame(60, 1'b1);
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b expected 0", o_locked); end
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL lock_after3: got %b expected 1", o_locked); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL lock_err_count: got %0d expected 0", n_err); end
    total++; if (n_dly_bad !== 0) begin bad++; $display("FAIL lock_sync_delay: got %0d bad cycles expected 0", n_dly_bad); end
    total++; if (n_pos_bad !== 0) begin bad++; $display("FAIL lock_position: got %0d bad cycles expected 0", n_pos_bad); end
    total++; if (o_frame_cnt !== 8'd3) begin bad++; $display("FAIL lock_frame_cnt: got %0d expected 3", o_frame_cnt); end
  endtask

  task automatic test_short_frame();
    clear_stats();
    frame(55, 1'b1);
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL short_unlock: got %b expected 0", o_locked); end
    total++; if (err_col !== 4 || err_row !== 5) begin bad++; $display("FAIL short_err_pos: got (%0d,%0d) expected (4,5)", err_col, err_row); end
    frame(60, 1'b1);
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL short_relock: got %b expected 1", o_locked); end
    total++; if (n_err !== 1) begin bad++; $display("FAIL short_err_count: got %0d expected 1", n_err); end
    total++; if (n_pos_bad !== 0) begin bad++; $display("FAIL short_position: got %0d bad cycles expected 0", n_pos_bad); end
    total++; if (o_frame_cnt !== 8'(fs_exp)) begin bad++; $display("FAIL short_frame_cnt: got %0d expected %0d", o_frame_cnt, fs_exp % 256); end
  endtask

  task automatic test_missing_vsync();
    int fs_before;
    clear_stats();
    fs_before = fs_exp;
    frame(60, 1'b0);
    total++; if (n_err !== 1) begin bad++; $display("FAIL miss_err_count: got %0d expected 1", n_err); end
    total++; if (err_col !== 9 || err_row !== 5) begin bad++; $display("FAIL miss_err_pos: got (%0d,%0d) expected (9,5)", err_col, err_row); end
    total++; if (pos2_col !== 0 || pos2_row !== 0) begin bad++; $display("FAIL miss_freewheel: got (%0d,%0d) expected (0,0)", pos2_col, pos2_row); end
    total++; if (o_frame_cnt !== 8'(fs_before)) begin bad++; $display("FAIL miss_frame_cnt: got %0d expected %0d", o_frame_cnt, fs_before % 256); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL miss_unlock: got %b expected 0", o_locked); end
    frame(60, 1'b1);
    frame(60, 1'b1);
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL miss_relock: got %b expected 1", o_locked); end
    total++; if (n_pos_bad !== 0) begin bad++; $display("FAIL miss_position: got %0d bad cycles expected 0", n_pos_bad); end
  endtask

  task automatic test_active_sweep();
    clear_stats();
    frame(60, 1'b1);
    total++; if (n_active !== 32) begin bad++; $display("FAIL active_count: got %0d expected 32", n_active); end
    total++; if (n_act_bad !== 0) begin bad++; $display("FAIL active_decode: got %0d bad cycles expected 0", n_act_bad); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    frame(27, 1'b1);
    total++; if (o_col_count !== 4'd4 || o_row_count !== 3'd2) begin bad++; $display("FAIL mid_pos: got (%0d,%0d) expected (4,2)", o_col_count, o_row_count); end
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked: got %b expected 1", o_locked); end
    i_rst_n = 1'b0;
    #1;
    total++; if (o_col_count !== 4'd0 || o_row_count !== 3'd0) begin bad++; $display("FAIL mid_rst_pos: got (%0d,%0d) expected (0,0)", o_col_count, o_row_count); end
    total++; if (o_locked !== 1'b0 || o_err !== 1'b0 || o_active !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got lock=%b err=%b act=%b expected 0 0 0", o_locked, o_err, o_active); end
    total++; if (o_frame_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_frame_cnt: got %0d expected 0", o_frame_cnt); end
    total++; if (o_vsync !== 1'b0 || o_hsync !== 1'b0) begin bad++; $display("FAIL mid_rst_syncs: got v=%b h=%b expected 0 0", o_vsync, o_hsync); end
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    vs_hist = 4'd0; hs_hist = 4'd0; mvalid = 1'b0; fs_exp = 0; prev_fc = 0;
    idle(5);
    total++; if (o_locked !== 1'b0 || o_frame_cnt !== 8'd0) begin bad++; $display("FAIL mid_post_idle: got lock=%b fc=%0d expected 0 0", o_locked, o_frame_cnt); end
    clear_stats();
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL mid_first_frame_lock: got %b expected 0", o_locked); end
    frame(60, 1'b1);
    frame(60, 1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL mid_relock: got %b expected 1", o_locked); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL mid_err_count: got %0d expected 0", n_err); end
  endtask

  task automatic test_frame_wrap();
    clear_stats();
    saw_wrap = 1'b0;
    repeat (300) frame(60, 1'b1);
    total++; if (n_err !== 0) begin bad++; $display("FAIL wrap_err_count: got %0d expected 0", n_err); end
    total++; if (saw_wrap !== 1'b1) begin bad++; $display("FAIL wrap_seen: got %b expected 1", saw_wrap); end
    total++; if (o_frame_cnt !== 8'd47) begin bad++; $display("FAIL wrap_frame_cnt: got %0d expected 47", o_frame_cnt); end
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL wrap_locked: got %b expected 1", o_locked); end
    total++; if (n_pos_bad !== 0 || n_dly_bad !== 0) begin bad++; $display("FAIL wrap_tracking: got pos=%0d dly=%0d expected 0 0", n_pos_bad, n_dly_bad); end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_short_frame();
    test_missing_vsync();
    test_active_sweep();
    test_reset_mid();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_track.md
SYNC_TRACK -- requirements
Module: sync_track

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, columns per line including blanking.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, lines per frame including blanking.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, visible columns counted from col 0.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, visible rows counted from row 0.
REQ-005 SHALL have parameter COL_W, default 10, width of the column counter; COL_W-bit unsigned must represent TOTAL_COLS-1.
REQ-006 SHALL have parameter ROW_W, default 10, width of the row counter; ROW_W-bit unsigned must represent TOTAL_ROWS-1.
REQ-007 SHALL have parameter SYNC_DELAY, default 1, range 1..4, input-to-output sync latency in clocks.
REQ-008 SHALL have parameters HSYNC_POL and VSYNC_POL, default 1, where 1 means the sync is active-high.
REQ-009 SHALL have parameter LOCK_FRAMES, default 2, range 1..15, consecutive good frames required for lock.
REQ-010 SHALL have port i_clk, input, 1 bit, the single pixel clock; all logic runs on its rising edge.
REQ-011 SHALL have port i_rst_n, input, 1 bit, reset; asynchronous assertion, active-low.
REQ-012 SHALL have ports i_hsync and i_vsync, inputs, 1 bit each, incoming syncs that are already synchronous to i_clk.
REQ-013 SHALL have ports o_hsync and o_vsync, outputs, 1 bit each, the input syncs delayed by SYNC_DELAY clocks with polarity preserved.
REQ-014 SHALL have port o_col_count, output, COL_W bits, the column position aligned to the output syncs.
REQ-015 SHALL have port o_row_count, output, ROW_W bits, the row position aligned to the output syncs.
REQ-016 SHALL have port o_active, output, 1 bit, high while the current position is inside the visible area.
REQ-017 SHALL have port o_locked, output, 1 bit, high while the incoming frame timing matches TOTAL_COLS x TOTAL_ROWS.
REQ-018 SHALL have port o_err, output, 1 bit, a one-clock pulse on each timing mismatch.
REQ-019 SHALL have port o_frame_cnt, output, 8 bits, count of frame starts; wraps 255 -> 0.

Function
REQ-020 Sync path SHALL be a SYNC_DELAY-stage shift register per sync; the output is the last stage.
REQ-021 A frame start SHALL be detected when the stage feeding o_vsync is asserted (per VSYNC_POL) and o_vsync is deasserted, i.e. at the vsync assertion edge.
REQ-022 On a frame start both counters SHALL load 0, so that count (0,0) appears in the first cycle o_vsync is asserted.
REQ-023 Otherwise the column counter SHALL increment by one, wrap TOTAL_COLS-1 -> 0 and advance the row counter, with the row counter wrapping TOTAL_ROWS-1 -> 0; this is the freewheel behaviour.
REQ-024 The hsync input SHALL NOT alter the counters; it is delayed only.
REQ-025 o_active SHALL be the combinational decode (o_col_count < ACTIVE_COLS) && (o_row_count < ACTIVE_ROWS), with zero latency relative to the counters.
REQ-026 The "wrap point" SHALL be the cycle with o_col_count == TOTAL_COLS-1 and o_row_count == TOTAL_ROWS-1.
REQ-027 A good frame SHALL be a frame start coinciding with the wrap point.
REQ-028 A mismatch SHALL be a frame start away from the wrap point, or the wrap point reached without a frame start.
REQ-029 The lock FSM SHALL use the states UNLOCKED, ACQUIRE and LOCKED with a 4-bit good-frame counter.
REQ-030 In UNLOCKED, the first frame start SHALL move the FSM to ACQUIRE with good=0.
REQ-031 In UNLOCKED, no mismatch SHALL be flagged.
REQ-032 In ACQUIRE, a good frame SHALL increment good; on reaching LOCK_FRAMES the FSM SHALL move to LOCKED.
REQ-033 In ACQUIRE, a mismatch SHALL clear good, pulse o_err and keep the FSM in ACQUIRE.
REQ-034 In LOCKED, a mismatch SHALL pulse o_err, move the FSM to ACQUIRE and clear good.
REQ-035 o_locked SHALL be registered, equal to (state == LOCKED), and valid the cycle after the transition.
REQ-036 o_frame_cnt SHALL increment on every frame start in all states.
REQ-037 A frame start at the wrap point SHALL count as exactly one event: one good frame, no o_err.

Reset
REQ-038 While i_rst_n is low: counters, o_frame_cnt, o_err and o_locked SHALL be 0, and the FSM SHALL be UNLOCKED.
REQ-039 While i_rst_n is low, all sync stages and o_hsync/o_vsync SHALL hold their deasserted level (~HSYNC_POL / ~VSYNC_POL).
REQ-040 Reset mid-frame SHALL force a fresh frame-start edge before any count alignment or lock attempt; release is synchronous to i_clk.

Structure
REQ-041 FSM state encoding and default 640x480 timing constants SHALL live in a shared package, vga_timing_pkg.
REQ-042 The sync delay line SHALL be one sub-module, sync_pipe (parameters DEPTH and POL), instantiated once per sync.

Verification (TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE 8x4, LOCK_FRAMES=2, SYNC_DELAY=3, polarities=1)
REQ-043 Regular vsync every 60 clocks -> o_vsync is i_vsync delayed 3 clocks; (0,0) coincides with o_vsync rising; o_locked=1 after the 3rd frame start; o_err never pulses.
REQ-044 Once locked, one frame shortened to 55 clocks -> single o_err pulse; o_locked falls; relocks after 2 further good frames.
REQ-045 Once locked, one vsync omitted -> o_err at (9,5); counters freewheel to (0,0); o_frame_cnt does not increment.
REQ-046 Counter sweep -> o_active=1 exactly for col 0..7 and row 0..3, i.e. 32 cycles per frame.
REQ-047 i_rst_n low at count (4,2) while LOCKED -> all outputs 0 immediately; o_vsync/o_hsync deasserted; UNLOCKED until the next vsync edge.
REQ-048 300 good frames -> o_frame_cnt wraps 255 -> 0 with no o_err.
